uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8-bit, one-sample-per-bit receiver.
- Oversamples the serial line, confirms start bits with a glitch filter, and samples each bit at mid-bit.
- Data width and stop-bit count are configurable.
- Reports framing and overrun errors alongside the existing dr/dr_rst data-ready handshake.
- Sits between the pad-level RX input and byte-consuming logic (FIFOs, command decoders).

Parameters:
DATA_BITS, 8, payload bits per frame, legal 5..9
OVS, 16, clk cycles per bit period, even, legal 4..256
STOP_BITS, 1, stop bits checked per frame, legal 1 or 2
PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined: 0 = even, 1 = odd

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
in  input  1  asynchronous serial line, idle high
out  output  DATA_BITS  last good frame payload, LSB = first received bit
dr  output  1  data ready, sticky until cleared via dr_rst
dr_rst  input  1  level clear of dr, ovr and ferr (and perr when present)
ovr  output  1  overrun: a good frame arrived while dr was still high
ferr  output  1  framing error: a stop bit was sampled low

Behaviour:
- One clock: clk. Reset is synchronous and active-high: rst sampled high at a rising clk edge resets the block.
- Reset values: out=0, dr=0, ovr=0, ferr=0, perr=0; FSM=IDLE; counters=0; synchroniser flops=1.
- rst has priority over everything, including mid-frame; a partial frame is discarded.
- in passes through a 2-flop synchroniser; all decisions use the synchronised line (s_in).
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE:
  - s_in==0 -> START; clear the sample counter.
- START:
  - Requires OVS/2 consecutive low samples.
  - Any high sample before that -> IDLE (false start, no flags).
  - On confirmation, the counter restarts; the block is now at mid-start-bit.
- DATA:
  - Every OVS clks, sample s_in into a shift register, LSB first.
  - After DATA_BITS samples -> PARITY if enabled, else STOP.
- STOP:
  - Every OVS clks, sample a stop bit; STOP_BITS samples in total.
  - Any low sample sets an internal bad-frame flag.
  - After the last stop sample:
    - Bad frame: set ferr; out and dr unchanged.
    - Good frame: load out; set dr; if dr was already 1 at that edge, also set ovr.
  - Go to IDLE immediately at mid-stop-bit, so the next start edge can be caught.
- Latency: D = 2 + OVS/2 + OVS*(DATA_BITS + P + STOP_BITS) clks (P=1 with parity, else 0).
  - Measured from edge E0, the first rising edge at which in is sampled 0.
  - dr reads high after edge E0+D.
- dr_rst:
  - Level-sensitive; each clock it is high clears dr, ovr, ferr and perr.
  - Coincident with a frame completion, the set wins; dr_rst does not affect FSM progress.
- Line stuck low: after a framing error the FSM re-enters START from IDLE. ferr is set once per frame period; no lock-up.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - Adds the PARITY state and output port perr (1 bit, reset 0).
  - One extra bit is sampled OVS clks after the last data bit and checked per PARITY_ODD.
  - Mismatch sets perr and discards the frame (out and dr unchanged). ferr is still evaluated independently.
- Undefined:
  - No parity state and no perr port; PARITY_ODD is ignored.

Decomposition:
- Package uart_pkg holds:
  - FSM state encoding (IDLE/START/DATA/PARITY/STOP) as a localparam set.
  - Parity-sense constants PAR_EVEN=0, PAR_ODD=1.
  - Counter width function clog2(OVS).
- Sub-module uart_sync: 2-flop synchroniser, reset to 1. It is reused by the future TX loopback and by other async inputs.

Test Plan:
- Defaults, frame 0x55 (start, 10101010 LSB-first, stop), bit period 16 clks -> out=0x55, dr rises exactly 154 clks after E0; ovr=0, ferr=0.
- Line low for 7 clks, then high -> FSM returns to IDLE; no flags. A following 0xA3 frame is received correctly.
- Frame 0x3C with stop bit forced low -> ferr=1, dr=0, out keeps its previous value. dr_rst pulse for 1 clk -> ferr=0.
- Two back-to-back frames 0x12, 0x34 without dr_rst -> out=0x34, dr=1, ovr=1. dr_rst high on the same edge as frame completion -> dr stays 1.
- DATA_BITS=7, STOP_BITS=2, second stop bit low -> ferr=1, no dr.
- With UART_RX_PARITY_EN, PARITY_ODD=0, frame 0x07 with parity bit 0 -> perr=1, no dr; parity 1 -> out=0x07, dr=1.
- rst asserted mid-DATA -> next edge: all outputs 0, FSM IDLE; a subsequent clean frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM encoding, parity sense and counter sizing.
// Pure constants; no latency, no flow control.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous idle-high input; 2 clk latency, no backpressure.
// Both stages reset to 1 so a line held idle never produces a spurious low.
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver; dr rises 2 + OVS/2 + OVS*(DATA_BITS+P+STOP_BITS) clks after the first low sample.
// No backpressure: dr is sticky until dr_rst, later good frames overwrite out and flag ovr. Parity via UART_RX_PARITY_EN.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVS        = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in,
  output logic [DATA_BITS-1:0] out,
  output logic                 dr,
  input  logic                 dr_rst,
  output logic                 ovr,
  output logic                 ferr
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 perr
`endif
);

  localparam int              CW        = clog2(OVS);
  localparam logic [CW-1:0]   HALF_LAST = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(OVS - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0]      DATA_NEXT = ST_PARITY;
  localparam logic            PAR_LVL   = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
`else
  localparam logic [2:0]      DATA_NEXT = ST_STOP;
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  logic                 s_in;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 bad_q, bad_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 dr_q, dr_d;
  logic                 ovr_q, ovr_d;
  logic                 ferr_q, ferr_d;
  logic                 half_tick, bit_tick, stop_done, frame_bad, par_bad;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
`endif

  uart_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (in),
    .sync_out (s_in)
  );

  assign half_tick = (cnt_q == HALF_LAST);
  assign bit_tick  = (cnt_q == BIT_LAST);
  assign stop_done = (state_q == ST_STOP) && bit_tick && (bit_q == STOP_LAST);
  assign frame_bad = bad_q | ~s_in;
`ifdef UART_RX_PARITY_EN
  assign par_bad   = ((^shift_q) ^ par_q) != PAR_LVL;
`else
  assign par_bad   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      bad_q   <= 1'b0;
      out_q   <= '0;
      dr_q    <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      bad_q   <= bad_d;
      out_q   <= out_d;
      dr_q    <= dr_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!s_in) state_d = ST_START;
      ST_START:  if (s_in) state_d = ST_IDLE;
                 else if (half_tick) state_d = ST_DATA;
      ST_DATA:   if (bit_tick && (bit_q == DATA_LAST)) state_d = DATA_NEXT;
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (bit_tick) state_d = ST_STOP;
`endif
      ST_STOP:   if (stop_done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = bit_tick ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    bad_d   = bad_q;
    out_d   = out_q;
    dr_d    = dr_q & ~dr_rst;
    ovr_d   = ovr_q & ~dr_rst;
    ferr_d  = ferr_q & ~dr_rst;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q & ~dr_rst;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        bad_d = 1'b0;
      end
      ST_START: cnt_d = (s_in || half_tick) ? '0 : cnt_q + 1'b1;
      ST_DATA: if (bit_tick) begin
        shift_d = {s_in, shift_q[DATA_BITS-1:1]};
        bit_d   = (bit_q == DATA_LAST) ? 4'd0 : bit_q + 4'd1;
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (bit_tick) par_d = s_in;
`endif
      ST_STOP: if (bit_tick) begin
        bit_d = bit_q + 4'd1;
        bad_d = frame_bad;
      end
      default: cnt_d = '0;
    endcase
    // Completion sets outrank a coincident dr_rst clear.
    if (stop_done) begin
      if (frame_bad) ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
      if (par_bad) perr_d = 1'b1;
`endif
      if (!frame_bad && !par_bad) begin
        out_d = shift_q;
        dr_d  = 1'b1;
        if (dr_q) ovr_d = 1'b1;
      end
    end
  end

  assign out  = out_q;
  assign dr   = dr_q;
  assign ovr  = ovr_q;
  assign ferr = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign perr = perr_q;
`endif

endmodule
